// File: rtl/gb_lcd_pkg.sv
// gb_lcd_pkg
//   Mode codes and timing defaults shared by the dot sequencer and the LCD
//   output stage, plus the per-dot mode decode used by the sequencer.
//   Mode codes: 0 h-blank, 1 v-blank, 2 OAM scan, 3 pixel transfer.
package gb_lcd_pkg;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam int LCD_DOTS_PER_LINE = 456;
  localparam int LCD_LINES         = 154;
  localparam int LCD_VIS_LINES     = 144;
  localparam int LCD_OAM_DOTS      = 80;
  localparam int LCD_XFER_MIN      = 172;
  localparam int LCD_H_PIX         = 160;

  // Mode for one dot position. The first line after the LCD comes on reports
  // h-blank instead of OAM scan during the OAM window.
  function automatic logic [1:0] dot_mode(input logic vis,
                                          input logic first,
                                          input logic in_oam,
                                          input logic in_xfer);
    logic [1:0] m;
    if (!vis)         m = MODE_VBLANK;
    else if (in_oam)  m = first ? MODE_HBLANK : MODE_OAM;
    else if (in_xfer) m = MODE_XFER;
    else              m = MODE_HBLANK;
    return m;
  endfunction

endpackage

// File: rtl/lcd_stat_irq.sv
// lcd_stat_irq
//   Builds the combined STAT interrupt line from the registered mode and LY
//   compare flag and emits a one-clock pulse on its rising edge only, so a
//   second source becoming active while the line is already high is blocked.
// Ports
//   clk_i        core clock
//   clr_i        synchronous clear (reset or LCD off)
//   mode_i       current mode code
//   lyc_match_i  registered LY==LYC
//   stat_en_i    source enables {lyc, mode2, mode1, mode0}
//   stat_irq_o   one-clock interrupt pulse
module lcd_stat_irq
  import gb_lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic [1:0] mode_i,
  input  logic       lyc_match_i,
  input  logic [3:0] stat_en_i,
  output logic       stat_irq_o
);

  logic line;
  logic line_q;
  logic irq_q;

  always_comb begin
    line = ((mode_i == MODE_HBLANK) & stat_en_i[0]) |
           ((mode_i == MODE_VBLANK) & stat_en_i[1]) |
           ((mode_i == MODE_OAM)    & stat_en_i[2]) |
           (lyc_match_i             & stat_en_i[3]);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      line_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      line_q <= line;
      irq_q  <= line & ~line_q;
    end
  end

  assign stat_irq_o = irq_q;

endmodule

// File: rtl/lcd_mode_sequencer.sv
// lcd_mode_sequencer
//   Dot-level PPU timing controller. Walks dot/line counters on each dot
//   enable, derives the mode code (2 OAM, 3 transfer, 0 h-blank, 1 v-blank),
//   strobes the line buffer once per pixel in the tail of mode 3, and raises
//   LY compare, v-blank and STAT interrupt indications.
//   Build option: define LCD_STAT_IRQ_EN to include the STAT interrupt
//   logic; without it stat_irq_o is tied low and stat_en_i is ignored.
// Ports
//   clk_i         core clock
//   reset_i       synchronous active-high reset
//   ce_i          dot enable; timing advances only when high
//   lcd_on_i      LCD enable; low holds everything at reset values
//   lyc_i         LY compare value
//   xfer_extra_i  extra mode-3 dots, sampled at the last OAM dot
//   stat_en_i     STAT source enables {lyc, mode2, mode1, mode0}
//   mode_o        current mode code
//   ly_o          current line
//   dot_o         dot within the line
//   pix_ena_o     one-clock strobe per pixel to the line buffer
//   lyc_match_o   registered ly==lyc
//   vblank_irq_o  pulse when LY enters the first v-blank line
//   stat_irq_o    pulse on STAT line rising edge
module lcd_mode_sequencer
  import gb_lcd_pkg::*;
#(
  parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int LINES         = LCD_LINES,
  parameter int VIS_LINES     = LCD_VIS_LINES,
  parameter int OAM_DOTS      = LCD_OAM_DOTS,
  parameter int XFER_MIN      = LCD_XFER_MIN,
  parameter int H_PIX         = LCD_H_PIX
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ce_i,
  input  logic       lcd_on_i,
  input  logic [7:0] lyc_i,
  input  logic [6:0] xfer_extra_i,
  input  logic [3:0] stat_en_i,
  output logic [1:0] mode_o,
  output logic [7:0] ly_o,
  output logic [8:0] dot_o,
  output logic       pix_ena_o,
  output logic       lyc_match_o,
  output logic       vblank_irq_o,
  output logic       stat_irq_o
);

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_LAST = 9'(OAM_DOTS - 1);
  localparam logic [7:0] LY_LAST  = 8'(LINES - 1);
  localparam logic [7:0] VIS_LAST = 8'(VIS_LINES - 1);
  localparam logic [7:0] VIS_END  = 8'(VIS_LINES);
  localparam logic [8:0] XMIN     = 9'(XFER_MIN);
  localparam logic [9:0] OAM_W    = 10'(OAM_DOTS);
  localparam logic [9:0] HPIX_W   = 10'(H_PIX);

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic [1:0] mode_q, mode_d;
  logic [8:0] xlen_q, xlen_d;
  logic       first_q, first_d;
  logic       pix_q, pix_d;
  logic       vbl_q, vbl_d;
  logic       lycm_q;

  logic       eol;
  logic [9:0] dot_w;
  logic [9:0] xfer_end;
  logic [9:0] pix_start;
  logic       vis, in_oam, in_xfer, in_pix;

  assign eol = (dot_q == DOT_LAST);

  // Position counters and first-line flag.
  always_comb begin
    dot_d   = dot_q;
    ly_d    = ly_q;
    first_d = first_q;
    if (ce_i) begin
      if (eol) begin
        dot_d   = '0;
        ly_d    = (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
        first_d = 1'b0;
      end else begin
        dot_d = dot_q + 9'd1;
      end
    end
  end

  // Transfer length is latched once on the last OAM dot so that penalty
  // changes arriving mid-transfer cannot stretch or shrink the current line.
  always_comb begin
    xlen_d = xlen_q;
    if (ce_i && dot_q == OAM_LAST)
      xlen_d = XMIN + {2'b00, xfer_extra_i};
  end

  // Window decode for the position being entered. The pixel window is the
  // tail of mode 3, so the strobe count per line is independent of xlen.
  always_comb begin
    dot_w     = {1'b0, dot_d};
    xfer_end  = OAM_W + {1'b0, xlen_d};
    pix_start = xfer_end - HPIX_W;
    vis       = (ly_d < VIS_END);
    in_oam    = (dot_w < OAM_W);
    in_xfer   = (dot_w < xfer_end);
    in_pix    = vis && !in_oam && in_xfer && (dot_w >= pix_start);
  end

  always_comb begin
    mode_d = mode_q;
    pix_d  = 1'b0;
    vbl_d  = 1'b0;
    if (ce_i) begin
      mode_d = dot_mode(vis, first_d, in_oam, in_xfer);
      pix_d  = in_pix;
      vbl_d  = eol && (ly_q == VIS_LAST);
    end
  end

  // LCD off behaves like reset and overrides the dot enable.
  always_ff @(posedge clk_i) begin
    if (reset_i || !lcd_on_i) begin
      dot_q   <= '0;
      ly_q    <= '0;
      mode_q  <= MODE_HBLANK;
      xlen_q  <= XMIN;
      first_q <= 1'b1;
      pix_q   <= 1'b0;
      vbl_q   <= 1'b0;
      lycm_q  <= 1'b0;
    end else begin
      dot_q   <= dot_d;
      ly_q    <= ly_d;
      mode_q  <= mode_d;
      xlen_q  <= xlen_d;
      first_q <= first_d;
      pix_q   <= pix_d;
      vbl_q   <= vbl_d;
      // Compared every clock against the live register, not only on ce.
      lycm_q  <= (ly_q == lyc_i);
    end
  end

  assign mode_o       = mode_q;
  assign ly_o         = ly_q;
  assign dot_o        = dot_q;
  assign pix_ena_o    = pix_q;
  assign lyc_match_o  = lycm_q;
  assign vblank_irq_o = vbl_q;

`ifdef LCD_STAT_IRQ_EN
  lcd_stat_irq u_stat (
    .clk_i       (clk_i),
    .clr_i       (reset_i | ~lcd_on_i),
    .mode_i      (mode_q),
    .lyc_match_i (lycm_q),
    .stat_en_i   (stat_en_i),
    .stat_irq_o  (stat_irq_o)
  );
`else
  logic unused_stat_en;
  assign unused_stat_en = ^stat_en_i;
  assign stat_irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
module tb_lcd_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset, ce, lcd_on;
  logic [7:0] lyc;
  logic [6:0] xfer_extra;
  logic [3:0] stat_en;
  logic [1:0] mode;
  logic [7:0] ly;
  logic [8:0] dot;
  logic       pix_ena, lyc_match, vblank_irq, stat_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_mode_sequencer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ce_i         (ce),
    .lcd_on_i     (lcd_on),
    .lyc_i        (lyc),
    .xfer_extra_i (xfer_extra),
    .stat_en_i    (stat_en),
    .mode_o       (mode),
    .ly_o         (ly),
    .dot_o        (dot),
    .pix_ena_o    (pix_ena),
    .lyc_match_o  (lyc_match),
    .vblank_irq_o (vblank_irq),
    .stat_irq_o   (stat_irq)
  );

  // Reference position / line state derived from spec timing.
  int m_dot, m_ly, m_xlen;
  bit m_first;
  int mm_cnt, pix_line, pix_frame, pix_bad;
  int vbl_cnt, vbl_ly, vbl_dot;
  int stat_all, stat_cnt, st_f_ly, st_f_dot, st_l_ly, st_l_dot;
  int first_pix [154];
  int pulse_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dot = 0; m_ly = 0; m_first = 1'b1; m_xlen = 172;
    mm_cnt = 0; pix_line = 0; pix_frame = 0; pix_bad = 0;
    vbl_cnt = 0; vbl_ly = -1; vbl_dot = -1;
    stat_all = 0; stat_cnt = 0;
    st_f_ly = -1; st_f_dot = -1; st_l_ly = -1; st_l_dot = -1;
    for (int i = 0; i < 154; i++) first_pix[i] = -1;
  endtask

  function automatic int exp_mode();
    if (m_ly >= 144)          return 1;
    if (m_dot < 80)           return m_first ? 0 : 2;
    if (m_dot < 80 + m_xlen)  return 3;
    return 0;
  endfunction

  task automatic tick(input bit c);
    bit ep;
    ce = c;
    @(posedge clk);
    if (c) begin
      if (m_dot == 79) m_xlen = 172 + int'(xfer_extra);
      if (m_dot == 455) begin
        if (m_ly < 144 && pix_line != 160) pix_bad++;
        pix_line = 0;
        m_dot = 0;
        m_first = 1'b0;
        m_ly = (m_ly == 153) ? 0 : m_ly + 1;
      end else begin
        m_dot++;
      end
    end
    #1;
    ep = c && m_ly < 144 && m_dot >= 80 + m_xlen - 160 && m_dot < 80 + m_xlen;
    if (dot !== m_dot[8:0] || ly !== m_ly[7:0] || int'(mode) != exp_mode() || pix_ena !== ep)
      mm_cnt++;
    if (pix_ena) begin
      if (pix_line == 0) first_pix[m_ly] = m_dot;
      pix_line++;
      pix_frame++;
    end
    if (vblank_irq) begin vbl_cnt++; vbl_ly = int'(ly); vbl_dot = int'(dot); end
    if (stat_irq) begin
      stat_all++;
      if (ly == 8'd5 || ly == 8'd6) begin
        stat_cnt++;
        if (stat_cnt == 1) begin st_f_ly = int'(ly); st_f_dot = int'(dot); end
        st_l_ly = int'(ly); st_l_dot = int'(dot);
      end
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; lcd_on = 1'b1;
    lyc = 8'd5; xfer_extra = 7'd0; stat_en = 4'b1001;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_ly", ly, 0);
    chk("rst_dot", dot, 0);
    chk("rst_pix", pix_ena, 0);
    chk("rst_lycm", lyc_match, 0);
    chk("rst_vbl", vblank_irq, 0);
    chk("rst_stat", stat_irq, 0);

    // Lines 0..10 from reset, extra=0, lyc=5 with {lyc, mode0} STAT sources.
    reset = 1'b0;
    for (int i = 1; i <= 10 * 456 + 200; i++) begin
      tick(1'b1);
      if (i == 79)  chk("l0_d79_mode", mode, 0);
      if (i == 80)  chk("l0_d80_mode", mode, 3);
      if (i == 251) chk("l0_d251_mode", mode, 3);
      if (i == 252) chk("l0_d252_mode", mode, 0);
      if (i == 455) chk("l0_d455_mode", mode, 0);
      if (i == 456) begin
        chk("l1_d0_mode", mode, 2);
        chk("l1_d0_ly", ly, 1);
        chk("l1_d0_dot", dot, 0);
      end
      if (i == 5 * 456)     chk("lycm_ly5_d0", lyc_match, 0);
      if (i == 5 * 456 + 1) chk("lycm_ly5_d1", lyc_match, 1);
      if (i == 10 * 456 + 200) begin
        chk("drop_pre_mode", mode, 3);
        chk("drop_pre_pix", pix_ena, 1);
      end
    end
    chk("a_model_mm", mm_cnt, 0);
    chk("a_first_pix_l0", first_pix[0], 92);
    chk("a_pix_bad", pix_bad, 0);
`ifdef LCD_STAT_IRQ_EN
    chk("stat_cnt_ly5_6", stat_cnt, 2);
    chk("stat_first_ly", st_f_ly, 5);
    chk("stat_first_dot", st_f_dot, 2);
    chk("stat_last_ly", st_l_ly, 6);
    chk("stat_last_dot", st_l_dot, 253);
`else
    chk("stat_off_pulses", stat_all, 0);
`endif

    // LCD off with ce low forces reset values on the next clock.
    lcd_on = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
    chk("off_mode", mode, 0);
    chk("off_ly", ly, 0);
    chk("off_dot", dot, 0);
    chk("off_pix", pix_ena, 0);
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("off_hold_dot", dot, 0);

    // Re-enable: full frame with extra=20, line 7 uses extra=127 and a
    // mid-transfer change that must be ignored.
    lcd_on = 1'b1; xfer_extra = 7'd20;
    model_reset();
    for (int i = 1; i <= 70224; i++) begin
      if (m_ly == 7 && m_dot == 0)   xfer_extra = 7'd127;
      if (m_ly == 7 && m_dot == 200) xfer_extra = 7'd0;
      if (m_ly == 8 && m_dot == 0)   xfer_extra = 7'd20;
      tick(1'b1);
      if (m_ly == 0 && m_dot == 79)  chk("on_l0_d79_mode", mode, 0);
      if (m_ly == 0 && m_dot == 80)  chk("on_l0_d80_mode", mode, 3);
      if (m_ly == 1 && m_dot == 271) chk("x20_d271_mode", mode, 3);
      if (m_ly == 1 && m_dot == 272) chk("x20_d272_mode", mode, 0);
      if (m_ly == 7 && m_dot == 378) chk("x127_d378_mode", mode, 3);
      if (m_ly == 7 && m_dot == 379) chk("x127_d379_mode", mode, 0);
      if (m_ly == 144 && m_dot == 0) begin
        chk("vbl_entry_mode", mode, 1);
        chk("vbl_entry_irq", vblank_irq, 1);
      end
      if (m_ly == 153 && m_dot == 455) chk("l153_mode", mode, 1);
    end
    chk("wrap_ly", ly, 0);
    chk("wrap_dot", dot, 0);
    chk("wrap_mode", mode, 2);
    chk("vbl_cnt", vbl_cnt, 1);
    chk("vbl_ly", vbl_ly, 144);
    chk("vbl_dot", vbl_dot, 0);
    chk("pix_frame", pix_frame, 23040);
    chk("pix_bad_lines", pix_bad, 0);
    chk("first_pix_l0", first_pix[0], 112);
    chk("first_pix_l1", first_pix[1], 112);
    chk("first_pix_l7", first_pix[7], 219);
    chk("b_model_mm", mm_cnt, 0);

    // ce 1-of-4, then reset mid-transfer.
    lyc = 8'd0;
    mm_cnt = 0;
    for (int k = 0; k < 1000 && m_dot < 120; k++) begin
      tick(k % 4 == 0);
      if (k % 4 == 0 && m_dot == 112) chk("ce4_pix_on", pix_ena, 1);
      if (k % 4 == 1 && m_dot == 112) chk("ce4_pix_gap", pix_ena, 0);
    end
    chk("ce4_mm", mm_cnt, 0);
    chk("ce4_pre_mode", mode, 3);
    chk("ce4_pre_lycm", lyc_match, 1);
    reset = 1'b1; ce = 1'b0;
    @(posedge clk); #1;
    chk("rst3_mode", mode, 0);
    chk("rst3_ly", ly, 0);
    chk("rst3_dot", dot, 0);
    chk("rst3_pix", pix_ena, 0);
    chk("rst3_lycm", lyc_match, 0);
    chk("rst3_irqs", {vblank_irq, stat_irq}, 0);
    pulse_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      ce = (k % 4 == 0);
      @(posedge clk); #1;
      if (pix_ena || vblank_irq || stat_irq || dot != 9'd0) pulse_cnt++;
    end
    chk("rst_hold_stray", pulse_cnt, 0);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 100; k++) tick(k % 4 == 0);
    chk("post_rst_mm", mm_cnt, 0);
    chk("post_rst_dot", dot, 25);
    chk("post_rst_mode", mode, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
